// File: rtl/hazard3_trigger_break_ctrl_pkg.sv
// Shared constants and types for the trigger break controller.
package hazard3_trigger_break_ctrl_pkg;

    localparam int W_ADDR_DEFAULT  = 32;
    localparam int HOLDOFF_DEFAULT = 2;

    // Break controller FSM states
    typedef enum logic [1:0] {
        BRK_IDLE    = 2'd0,
        BRK_HOLD    = 2'd1,
        BRK_HOLDOFF = 2'd2
    } brk_state_e;

    // Holdoff down-counter width: enough to hold HOLDOFF_CYCLES without wrapping
    function automatic int holdoff_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard3_trigger_break_ctrl_if.sv
// Break request handshake toward the trap/debug-entry logic.
interface hazard3_trigger_break_ctrl_if #(
    parameter int W_ADDR = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_d_mode;
    logic [W_ADDR-1:0] req_pc;

    modport master (output req_valid, output req_d_mode, output req_pc, input req_ready);
    modport slave  (input req_valid, input req_d_mode, input req_pc, output req_ready);
endinterface

// File: rtl/hazard3_trigger_break_ctrl.sv
// Turns the trigger unit's combinational PC match into a registered, handshaked
// break request, kills the matching decode instruction, and implements the
// skip-once rule for resuming onto a breakpointed PC.
module hazard3_trigger_break_ctrl
    import hazard3_trigger_break_ctrl_pkg::*;
#(
    parameter int W_ADDR         = W_ADDR_DEFAULT,
    parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W_ADDR-1:0]       pc_d,
    input  logic                    pc_d_vld,
    input  logic                    pc_d_stall,
    input  logic                    flush,
    input  logic                    trig_break_any,
    input  logic                    trig_break_d_mode,
    input  logic                    resume,
    input  logic [W_ADDR-1:0]       resume_pc,
    output logic                    kill_d,
    hazard3_trigger_break_ctrl_if.master req
);

    localparam int                CNT_W    = holdoff_cnt_w(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    brk_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_valid_q, req_valid_d;
    logic              req_d_mode_q, req_d_mode_d;
    logic [W_ADDR-1:0] req_pc_q, req_pc_d;
    logic              skip_arm_q, skip_arm_d;
    logic [W_ADDR-1:0] skip_pc_q, skip_pc_d;
    logic              hit;
    logic              advance;

    // Qualified match: the skip latch suppresses only the exact resume PC
    always_comb begin
        advance = pc_d_vld && !pc_d_stall;
        hit     = pc_d_vld && trig_break_any && !(skip_arm_q && (pc_d == skip_pc_q));
        kill_d  = !rst && (((state_q == BRK_IDLE) && hit) || (state_q == BRK_HOLD));
    end

    // Next-state for FSM, holdoff counter, request payload and skip latch
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d_mode_d = req_d_mode_q;
        req_pc_d     = req_pc_q;
        skip_arm_d   = skip_arm_q;
        skip_pc_d    = skip_pc_q;

        case (state_q)
            BRK_IDLE: begin
                // A same-cycle flush means the instruction is gone anyway
                if (hit && !flush) begin
                    state_d      = BRK_HOLD;
                    req_d_mode_d = trig_break_d_mode;
                    req_pc_d     = pc_d;
                end
            end
            BRK_HOLD: begin
                // Acceptance beats a concurrent flush: the handshake has completed
                if (req.req_ready) begin
                    if (HOLDOFF_CYCLES <= 1) begin
                        state_d = BRK_IDLE;
                    end else begin
                        state_d = BRK_HOLDOFF;
                        cnt_d   = CNT_INIT;
                    end
                end else if (flush) begin
                    state_d = BRK_IDLE;
                end
            end
            BRK_HOLDOFF: begin
                if (cnt_q == '0) state_d = BRK_IDLE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = BRK_IDLE;
        endcase

        // Resume arms the skip even if decode advances or flushes the same cycle
        if (resume) begin
            skip_arm_d = 1'b1;
            skip_pc_d  = resume_pc;
        end else if (advance || flush) begin
            skip_arm_d = 1'b0;
        end

        req_valid_d = (state_d == BRK_HOLD);
    end

    // State registers; reset drops any pending request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BRK_IDLE;
            cnt_q        <= '0;
            req_valid_q  <= 1'b0;
            req_d_mode_q <= 1'b0;
            req_pc_q     <= '0;
            skip_arm_q   <= 1'b0;
            skip_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_valid_q  <= req_valid_d;
            req_d_mode_q <= req_d_mode_d;
            req_pc_q     <= req_pc_d;
            skip_arm_q   <= skip_arm_d;
            skip_pc_q    <= skip_pc_d;
        end
    end

    assign req.req_valid  = req_valid_q;
    assign req.req_d_mode = req_d_mode_q;
    assign req.req_pc     = req_pc_q;

endmodule

// File: tb/tb_hazard3_trigger_break_ctrl.sv
// Bench for hazard3_trigger_break_ctrl: directed scenarios then random traffic,
// all compared each cycle against a behavioural model of the break rules.
module tb_hazard3_trigger_break_ctrl;

    localparam int HOLDOFF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_d;
    logic        pc_d_vld, pc_d_stall, flush;
    logic        trig_break_any, trig_break_d_mode;
    logic        resume;
    logic [31:0] resume_pc;
    logic        kill_d;

    hazard3_trigger_break_ctrl_if #(.W_ADDR(32)) req_if ();

    hazard3_trigger_break_ctrl #(.W_ADDR(32), .HOLDOFF_CYCLES(HOLDOFF)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_d              (pc_d),
        .pc_d_vld          (pc_d_vld),
        .pc_d_stall        (pc_d_stall),
        .flush             (flush),
        .trig_break_any    (trig_break_any),
        .trig_break_d_mode (trig_break_d_mode),
        .resume            (resume),
        .resume_pc         (resume_pc),
        .kill_d            (kill_d),
        .req               (req_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: a pending request (or none), cycles of holdoff left, skip latch
    bit          m_pend;
    bit          m_dm;
    logic [31:0] m_pc;
    int          m_hold;
    bit          m_arm;
    logic [31:0] m_spc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pend = 0; m_dm = 0; m_pc = '0; m_hold = 0; m_arm = 0; m_spc = '0;
    endtask

    function automatic bit m_hit();
        return pc_d_vld && trig_break_any && !(m_arm && pc_d == m_spc);
    endfunction

    task automatic drive(input bit vld, input bit stall, input logic [31:0] pc, input bit any,
                         input bit dm, input bit fl, input bit rdy, input bit res,
                         input logic [31:0] rpc);
        pc_d_vld = vld; pc_d_stall = stall; pc_d = pc; trig_break_any = any;
        trig_break_d_mode = dm; flush = fl; req_if.req_ready = rdy; resume = res;
        resume_pc = rpc;
    endtask

    // Called at posedge+1: check at the negedge, advance the model, wait for next edge
    task automatic step();
        bit hit;
        #4;
        hit = m_hit();
        chk("kill_d",     {31'b0, kill_d},            {31'b0, m_pend || (!m_pend && m_hold == 0 && hit)});
        chk("req_valid",  {31'b0, req_if.req_valid},  {31'b0, m_pend});
        chk("req_pc",     req_if.req_pc,              m_pc);
        chk("req_d_mode", {31'b0, req_if.req_d_mode}, {31'b0, m_dm});
        if (m_pend) begin
            if (req_if.req_ready) begin m_pend = 0; m_hold = HOLDOFF; end
            else if (flush)       m_pend = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (hit && !flush) begin
            m_pend = 1; m_pc = pc_d; m_dm = trig_break_d_mode;
        end
        if (resume) begin m_arm = 1; m_spc = resume_pc; end
        else if ((pc_d_vld && !pc_d_stall) || flush) m_arm = 0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
            step();
        end
    endtask

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h200;

        rst = 1'b1;
        drive(1, 0, 32'h100, 1, 1, 0, 0, 0, 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        // Reset state, including kill_d forced low while a match is presented
        chk("rst_kill_d",    {31'b0, kill_d},            32'h0);
        chk("rst_req_valid", {31'b0, req_if.req_valid},  32'h0);
        chk("rst_req_pc",    req_if.req_pc,              32'h0);
        chk("rst_req_dmode", {31'b0, req_if.req_d_mode}, 32'h0);
        rst = 1'b0;
        idle(1);

        // M-mode match: kill same cycle, request next cycle
        drive(1, 0, 32'h100, 1, 0, 0, 0, 0, 32'h0);
        step();
        chk("mm_req_pc", req_if.req_pc, 32'h100);
        // Backpressure with changing decode PC
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h104 + 32'(4 * i), i[0], 1, 0, 0, 0, 32'h0);
            step();
        end
        drive(1, 0, 32'h120, 0, 0, 0, 1, 0, 32'h0);
        step();
        // Two holdoff cycles ignore matches, the third fires again
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h130, 1, 0, 0, 0, 0, 32'h0);
            step();
        end
        chk("holdoff_end_req", {31'b0, req_if.req_valid}, 32'h1);
        drive(0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        step();
        idle(3);

        // Skip once at 0x100, then 0x100 again fires
        drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h100);
        step();
        drive(1, 0, 32'h100, 1, 0, 0, 0, 0, 32'h0);
        step();
        drive(1, 0, 32'h100, 1, 0, 0, 0, 0, 32'h0);
        step();
        chk("skip_refire", {31'b0, req_if.req_valid}, 32'h1);
        drive(0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        step();
        idle(3);

        // Skip applies only to its PC
        drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h100);
        step();
        drive(1, 1, 32'h108, 1, 0, 0, 0, 0, 32'h0);
        step();
        drive(0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        step();
        idle(3);

        // Flush race: hit+flush drops; HOLD+flush+ready completes
        drive(1, 0, 32'h100, 1, 0, 1, 0, 0, 32'h0);
        step();
        drive(1, 0, 32'h104, 1, 0, 0, 0, 0, 32'h0);
        step();
        drive(1, 0, 32'h108, 1, 0, 1, 1, 0, 32'h0);
        step();
        drive(1, 0, 32'h10c, 1, 0, 0, 0, 0, 32'h0);
        step();
        idle(3);
        // HOLD + flush alone drops the request
        drive(1, 0, 32'h104, 1, 0, 0, 0, 0, 32'h0);
        step();
        drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
        step();
        idle(2);

        // D-mode request
        drive(1, 0, 32'h200, 1, 1, 0, 0, 0, 32'h0);
        step();
        chk("dmode_req", {31'b0, req_if.req_d_mode}, 32'h1);
        drive(0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        step();
        idle(3);

        // Async reset while HOLD with skip still armed
        drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h300);
        step();
        drive(1, 1, 32'h104, 1, 0, 0, 0, 0, 32'h0);
        step();
        drive(1, 1, 32'h104, 0, 0, 0, 0, 0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", {31'b0, req_if.req_valid}, 32'h0);
        chk("arst_kill_d",    {31'b0, kill_d},           32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 0, 32'h300, 1, 0, 0, 0, 0, 32'h0);
        step();
        drive(0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        step();
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(99) < 80, $urandom_range(99) < 25, pcs[$urandom_range(3)],
                  $urandom_range(99) < 35, $urandom_range(1) == 1, $urandom_range(99) < 10,
                  $urandom_range(99) < 50, $urandom_range(99) < 8, pcs[$urandom_range(3)]);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
